// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared width helper, constants and event type for the keypad
//             matrix scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Minimum width is 1 so that single-entry ranges still get a real bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int KP_MAX_CODE_W = 8;
    localparam int KP_DEF_CODE_W = clog2(16);
    localparam int KP_DEF_CNT_W  = clog2(3 + 1);

    typedef struct packed {
        logic                     press;
        logic [KP_MAX_CODE_W-1:0] code;
    } key_evt_t;

endpackage
`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_evt_fifo
//  Purpose  : Synchronous FIFO with valid/ready output and full flag.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    localparam int c_PTR_W = clog2(DEPTH);
    localparam int c_CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop;
    logic               w_push;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_pop   = o_valid && i_ready;
    // A pop frees the slot in the same clock, so a full FIFO still accepts.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + c_PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + c_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner
//  Purpose  : Row/column key-matrix scanner with dwell, per-key debounce,
//             n-key rollover and a press/release event FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SETTLE_CYC = 8,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         IN_clk,
    input  logic                         IN_reset,
    input  logic                         IN_en,
    input  logic [ROWS-1:0]              IN_row,
    output logic [COLS-1:0]              OUT_col,
    output logic                         OUT_valid,
    input  logic                         IN_ready,
    output logic [clog2(ROWS*COLS)-1:0]  OUT_code,
    output logic                         OUT_press,
    output logic                         OUT_held,
    output logic                         OUT_overflow
);
    localparam int c_KEYS    = ROWS * COLS;
    localparam int c_CODE_W  = clog2(c_KEYS);
    localparam int c_CNT_W   = clog2(DEBOUNCE + 1);
    localparam int c_COL_W   = clog2(COLS);
    localparam int c_ROW_W   = clog2(ROWS);
    localparam int c_DWELL_W = clog2(SETTLE_CYC);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                w_drive;
    logic                w_last_dwell;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [c_COL_W-1:0]  r_col_idx;

    logic [ROWS-1:0]     r_snap;
    logic [c_COL_W-1:0]  r_walk_col;
    logic [c_ROW_W-1:0]  r_walk_row;
    logic                r_walking;

    logic [c_KEYS-1:0]   r_stable;
    logic [c_CNT_W-1:0]  r_cnt [c_KEYS];
    logic                r_held;
    logic                r_overflow;

    logic [c_CODE_W-1:0] w_key;
    logic                w_sample;
    logic                w_differs;
    logic [c_CNT_W-1:0]  w_cnt_cur;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_commit_req;
    logic                w_can_push;
    logic                w_push;
    key_evt_t            w_evt;
    key_evt_t            w_fifo_out;
    logic                w_fifo_full;

    // ---------------- scan FSM ----------------
    always_ff @(posedge IN_clk) begin
        if (IN_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = IN_en ? ST_SCAN : ST_IDLE;
    end

    always_comb begin
        w_drive      = (r_state == ST_SCAN);
        w_last_dwell = w_drive && IN_en && (r_dwell == c_DWELL_W'(SETTLE_CYC - 1));
        OUT_col      = '0;
        for (int c = 0; c < COLS; c++) begin
            OUT_col[COLS-1-c] = w_drive && (r_col_idx == c_COL_W'(c));
        end
    end

    // Dwell counter, column index and row walker.
    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            r_dwell    <= '0;
            r_col_idx  <= '0;
            r_snap     <= '0;
            r_walk_col <= '0;
            r_walk_row <= '0;
            r_walking  <= 1'b0;
        end else begin
            if (!IN_en) begin
                r_dwell   <= '0;
                r_col_idx <= '0;
            end else if (w_drive) begin
                if (w_last_dwell) begin
                    r_dwell   <= '0;
                    r_col_idx <= (r_col_idx == c_COL_W'(COLS - 1)) ? '0
                                 : r_col_idx + c_COL_W'(1);
                end else begin
                    r_dwell <= r_dwell + c_DWELL_W'(1);
                end
            end

            if (w_last_dwell) begin
                r_snap     <= IN_row;
                r_walk_col <= r_col_idx;
                r_walk_row <= '0;
                r_walking  <= 1'b1;
            end else if (r_walking) begin
                if (r_walk_row == c_ROW_W'(ROWS - 1)) r_walking <= 1'b0;
                else r_walk_row <= r_walk_row + c_ROW_W'(1);
            end
        end
    end

    // ---------------- debounce of the key under the walker ----------------
    always_comb begin
        w_key        = c_CODE_W'(int'(r_walk_row) * COLS + int'(r_walk_col));
        w_sample     = r_snap[c_ROW_W'(ROWS - 1) - r_walk_row];
        w_differs    = (w_sample != r_stable[w_key]);
        w_cnt_cur    = r_cnt[w_key];
        w_cnt_inc    = (w_cnt_cur == c_CNT_W'(DEBOUNCE)) ? w_cnt_cur
                       : w_cnt_cur + c_CNT_W'(1);
        w_commit_req = r_walking && w_differs && (w_cnt_inc == c_CNT_W'(DEBOUNCE));
        w_can_push   = !w_fifo_full || (OUT_valid && IN_ready);
        w_push       = w_commit_req && w_can_push;
        w_evt.press  = w_sample;
        w_evt.code   = KP_MAX_CODE_W'(w_key);
    end

    // A refused commit leaves the counter saturated so the same event retries.
    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            r_stable   <= '0;
            r_held     <= 1'b0;
            r_overflow <= 1'b0;
            for (int k = 0; k < c_KEYS; k++) r_cnt[k] <= '0;
        end else begin
            r_held <= |r_stable;
            if (r_walking) begin
                if (!w_differs) begin
                    r_cnt[w_key] <= '0;
                end else if (w_push) begin
                    r_stable[w_key] <= w_sample;
                    r_cnt[w_key]    <= '0;
                end else begin
                    r_cnt[w_key] <= w_cnt_inc;
                    if (w_commit_req) r_overflow <= 1'b1;
                end
            end
        end
    end

    keypad_evt_fifo #(
        .WIDTH ($bits(key_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (IN_clk),
        .rst     (IN_reset),
        .i_push  (w_push),
        .i_data  (w_evt),
        .o_full  (w_fifo_full),
        .o_valid (OUT_valid),
        .i_ready (IN_ready),
        .o_data  (w_fifo_out)
    );

    assign OUT_code     = c_CODE_W'(w_fifo_out.code);
    assign OUT_press    = w_fifo_out.press;
    assign OUT_held     = r_held;
    assign OUT_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_matrix_scanner
//  Purpose  : Directed self-checking bench for keypad_matrix_scanner (4x4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ready;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        valid;
    logic [3:0]  code;
    logic        press;
    logic        held;
    logic        ovf;
    logic [15:0] keys;

    int n_checks = 0;
    int n_fail   = 0;
    int evq[$];

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(4), .SETTLE_CYC(8), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .IN_clk       (clk),
        .IN_reset     (rst),
        .IN_en        (en),
        .IN_row       (row),
        .OUT_col      (col),
        .OUT_valid    (valid),
        .IN_ready     (ready),
        .OUT_code     (code),
        .OUT_press    (press),
        .OUT_held     (held),
        .OUT_overflow (ovf)
    );

    // Key matrix: key r*4+c connects column c (col bit 3-c) to row r (row bit 3-r).
    always_comb begin
        row = '0;
        for (int c = 0; c < 4; c++) begin
            if (col[3-c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4+c]) row[3-r] = 1'b1;
                end
            end
        end
    end

    // Accepted events, encoded press*16 + code.
    always @(negedge clk) begin
        if (!rst && valid && ready) evq.push_back(int'(press) * 16 + int'(code));
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pop_evt();
        if (evq.size() == 0) return -1;
        return evq.pop_front();
    endfunction

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns on the first negedge of a fresh drive of column pattern t.
    task automatic wait_col(input logic [3:0] t);
        int budget;
        budget = 200;
        while (col == t && budget > 0) begin @(negedge clk); budget--; end
        while (col != t && budget > 0) begin @(negedge clk); budget--; end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_col: got timeout expected col %b", t);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; ready = 1'b1; keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst col",   col,   0);
        check_eq("rst valid", valid, 0);
        check_eq("rst code",  code,  0);
        check_eq("rst press", press, 0);
        check_eq("rst held",  held,  0);
        check_eq("rst ovf",   ovf,   0);

        // Test 1: single key r1,c2 -> code 6.
        keys[6] = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("t1 col pre", col, 4'b0000);
        @(negedge clk);
        check_eq("t1 col c0", col, 4'b1000);
        repeat (8) @(negedge clk);
        check_eq("t1 col c1", col, 4'b0100);
        clocks(160);
        check_eq("t1 n press", evq.size(), 1);
        check_eq("t1 press",   pop_evt(), 16 + 6);
        check_eq("t1 held",    held, 1);
        keys[6] = 1'b0;
        clocks(160);
        check_eq("t1 n rel", evq.size(), 1);
        check_eq("t1 rel",   pop_evt(), 6);
        check_eq("t1 held0", held, 0);

        // Test 2: r0,c0 bounces on,on,off per scan -> never reaches 3.
        for (int i = 0; i < 3; i++) begin
            wait_col(4'b0010); keys[0] = 1'b1;
            wait_col(4'b0010); keys[0] = 1'b1;
            wait_col(4'b0010); keys[0] = 1'b0;
        end
        clocks(128);
        check_eq("t2 no evt", evq.size(), 0);
        check_eq("t2 held",   held, 0);

        // Test 3: r0,c1 and r3,c1 together -> codes 1 then 13.
        keys[1] = 1'b1; keys[13] = 1'b1;
        clocks(160);
        check_eq("t3 n",   evq.size(), 2);
        check_eq("t3 e0",  pop_evt(), 16 + 1);
        check_eq("t3 e1",  pop_evt(), 16 + 13);
        keys[1] = 1'b0; keys[13] = 1'b0;
        clocks(160);
        check_eq("t3 n rel", evq.size(), 2);
        evq.delete();

        // Test 4: overflow with ready low; scan order gives 0,5,10,3 then 15.
        ready = 1'b0;
        wait_col(4'b1000);
        keys[0] = 1'b1; keys[5] = 1'b1; keys[10] = 1'b1; keys[3] = 1'b1; keys[15] = 1'b1;
        clocks(130);
        check_eq("t4 ovf",   ovf,   1);
        check_eq("t4 valid", valid, 1);
        check_eq("t4 code",  code,  0);
        check_eq("t4 press", press, 1);
        clocks(5);
        check_eq("t4 code stable", code, 0);
        ready = 1'b1;
        clocks(100);
        check_eq("t4 n",  evq.size(), 5);
        check_eq("t4 e0", pop_evt(), 16 + 0);
        check_eq("t4 e1", pop_evt(), 16 + 5);
        check_eq("t4 e2", pop_evt(), 16 + 10);
        check_eq("t4 e3", pop_evt(), 16 + 3);
        check_eq("t4 e4", pop_evt(), 16 + 15);
        keys = '0;
        clocks(160);
        evq.delete();

        // Test 5: reset during column 3 discards queued events and the stable map.
        ready = 1'b0;
        keys[2] = 1'b1; keys[9] = 1'b1;
        clocks(160);
        check_eq("t5 valid pre", valid, 1);
        check_eq("t5 held pre",  held,  1);
        check_eq("t5 ovf pre",   ovf,   1);
        wait_col(4'b0001);
        @(posedge clk); #1 rst = 1'b1;
        clocks(2);
        @(negedge clk);
        check_eq("t5 col",   col,   0);
        check_eq("t5 valid", valid, 0);
        check_eq("t5 held",  held,  0);
        check_eq("t5 ovf",   ovf,   0);
        check_eq("t5 code",  code,  0);
        ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        clocks(160);
        check_eq("t5 n",  evq.size(), 2);
        check_eq("t5 e0", pop_evt(), 16 + 9);
        check_eq("t5 e1", pop_evt(), 16 + 2);

        // Test 6: disable freezes scanning but not the stable map.
        @(posedge clk); #1 en = 1'b0;
        clocks(2);
        @(negedge clk);
        check_eq("t6 col off", col, 0);
        keys[2] = 1'b0; keys[9] = 1'b0;
        clocks(200);
        check_eq("t6 no evt",  evq.size(), 0);
        check_eq("t6 held",    held, 1);
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t6 col c0", col, 4'b1000);
        repeat (8) @(negedge clk);
        check_eq("t6 col c1", col, 4'b0100);
        clocks(160);
        check_eq("t6 n",     evq.size(), 2);
        check_eq("t6 e0",    pop_evt(), 9);
        check_eq("t6 e1",    pop_evt(), 2);
        check_eq("t6 held0", held, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
